// File: rtl/pipe_mem_io_pkg.sv
// pipe_mem_io_pkg
//   Shared constants and types for the MEM stage of the pipelined CPU:
//   the memory-mapped I/O address map (low byte of the address), the bit
//   that selects RAM versus I/O, the region type and the region decode.
package pipe_mem_io_pkg;

  // Bit of the byte address that selects the I/O window.
  localparam int IO_SEL_BIT = 7;

  // I/O register byte addresses; only bits [7:2] take part in the compare.
  localparam logic [7:0] IO_IN0   = 8'h80;
  localparam logic [7:0] IO_IN1   = 8'h84;
  localparam logic [7:0] IO_OUT0  = 8'hC0;
  localparam logic [7:0] IO_OUT1  = 8'hC4;
  localparam logic [7:0] IO_OUT2  = 8'hC8;
  localparam logic [7:0] IO_TIMER = 8'hD0;

  typedef enum logic {
    RGN_RAM = 1'b0,
    RGN_IO  = 1'b1
  } region_e;

  // Region decode: address bits above IO_SEL_BIT are ignored, so the map aliases.
  function automatic region_e decode_region(input logic [31:0] addr);
    return addr[IO_SEL_BIT] ? RGN_IO : RGN_RAM;
  endfunction

endpackage

// File: rtl/pipe_mem_io_stage_sync.sv
// io_input_sync
//   Two-flop synchroniser for one asynchronous board input port.
//   A change on d is sampled by the first flop and appears on q after the
//   second rising edge. Both flops clear on a synchronous active-low reset.
// Ports:
//   clock   in  1  system clock
//   resetn  in  1  synchronous active-low reset
//   d       in  W  asynchronous input
//   q       out W  synchronised output
module io_input_sync #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync1_d, sync1_q;
  logic [W-1:0] sync2_d, sync2_q;

  // Next state of the synchroniser chain.
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  // Synchroniser flops with synchronous clear.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/pipe_mem_io_stage.sv
// pipe_mem_io_stage
//   MEM stage of the 5-stage pipelined CPU. The ALU result is decoded as a
//   byte address into a word data RAM (bit 7 clear) or an I/O window
//   (bit 7 set). Stores happen on the rising edge; load data (mmo) is
//   combinational so the MEM/WB register captures it in the same cycle.
//   Build option: define PIPE_MEM_TIMER_EN to add a free-running 32-bit
//   cycle counter at 0xD0 (otherwise 0xD0 is unmapped).
// Ports:
//   clock        in   1      system clock
//   resetn       in   1      synchronous active-low reset
//   mwmem        in   1      store strobe
//   malu         in   32     effective byte address
//   mb           in   32     store data
//   in_port0/1   in   IN_W   asynchronous board inputs
//   mmo          out  32     load data to MEM/WB
//   out_port0..2 out  OUT_W  registered output ports
module pipe_mem_io_stage
  import pipe_mem_io_pkg::*;
#(
  parameter int RAM_AW = 5,
  parameter int IN_W   = 10,
  parameter int OUT_W  = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             mwmem,
  input  logic [31:0]      malu,
  input  logic [31:0]      mb,
  input  logic [IN_W-1:0]  in_port0,
  input  logic [IN_W-1:0]  in_port1,
  output logic [31:0]      mmo,
  output logic [OUT_W-1:0] out_port0,
  output logic [OUT_W-1:0] out_port1,
  output logic [OUT_W-1:0] out_port2
);

  localparam int RAM_DEPTH = 2 ** RAM_AW;

  logic [31:0]       ram_q [RAM_DEPTH];
  logic [RAM_AW-1:0] ram_idx_s;
  region_e           rgn_s;
  logic [7:0]        io_addr_s;
  logic              ram_we_s;
  logic              io_we_s;
  logic [OUT_W-1:0]  out0_d, out0_q;
  logic [OUT_W-1:0]  out1_d, out1_q;
  logic [OUT_W-1:0]  out2_d, out2_q;
  logic [IN_W-1:0]   in0_sync_s, in1_sync_s;
  logic              unused_addr_s;

  // Byte-offset bits and bits above the I/O select are deliberately ignored.
  assign unused_addr_s = ^{malu[31:8], malu[1:0]};

  io_input_sync #(.W(IN_W)) u_sync0 (
    .clock  (clock),
    .resetn (resetn),
    .d      (in_port0),
    .q      (in0_sync_s)
  );

  io_input_sync #(.W(IN_W)) u_sync1 (
    .clock  (clock),
    .resetn (resetn),
    .d      (in_port1),
    .q      (in1_sync_s)
  );

  // Address decode, write enables and next values of the output registers.
  always_comb begin
    rgn_s     = decode_region(malu);
    io_addr_s = {malu[7:2], 2'b00};
    ram_idx_s = malu[RAM_AW+1:2];
    ram_we_s  = mwmem && (rgn_s == RGN_RAM);
    io_we_s   = mwmem && (rgn_s == RGN_IO);
    out0_d    = (io_we_s && (io_addr_s == IO_OUT0)) ? mb[OUT_W-1:0] : out0_q;
    out1_d    = (io_we_s && (io_addr_s == IO_OUT1)) ? mb[OUT_W-1:0] : out1_q;
    out2_d    = (io_we_s && (io_addr_s == IO_OUT2)) ? mb[OUT_W-1:0] : out2_q;
  end

  // Data RAM: not reset, and a store coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (resetn && ram_we_s) begin
      ram_q[ram_idx_s] <= mb;
    end
  end

  // Output port registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      out0_q <= '0;
      out1_q <= '0;
      out2_q <= '0;
    end else begin
      out0_q <= out0_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end

`ifdef PIPE_MEM_TIMER_EN
  logic [31:0] timer_d, timer_q;

  // Timer next value: a store to the timer wins over the increment.
  always_comb begin
    timer_d = (io_we_s && (io_addr_s == IO_TIMER)) ? mb : (timer_q + 32'd1);
  end

  // Free-running cycle counter.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      timer_q <= 32'd0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  // Load mux: RAM word, I/O register or zero for unmapped I/O; no store forwarding.
  always_comb begin
    mmo = 32'h0;
    case (rgn_s)
      RGN_RAM: mmo = ram_q[ram_idx_s];
      RGN_IO: begin
        case (io_addr_s)
          IO_IN0:   mmo = 32'(in0_sync_s);
          IO_IN1:   mmo = 32'(in1_sync_s);
          IO_OUT0:  mmo = 32'(out0_q);
          IO_OUT1:  mmo = 32'(out1_q);
          IO_OUT2:  mmo = 32'(out2_q);
`ifdef PIPE_MEM_TIMER_EN
          IO_TIMER: mmo = timer_q;
`endif
          default:  mmo = 32'h0;
        endcase
      end
      default: mmo = 32'h0;
    endcase
  end

  assign out_port0 = out0_q;
  assign out_port1 = out1_q;
  assign out_port2 = out2_q;

endmodule

// File: tb/tb_pipe_mem_io_stage.sv
// Self-checking bench for pipe_mem_io_stage. Expected load data is pushed
// to a scoreboard queue when a load is driven and popped when mmo is sampled.
module tb_pipe_mem_io_stage;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        mwmem = 1'b0;
  logic [31:0] malu = 32'h0;
  logic [31:0] mb = 32'h0;
  logic [9:0]  in_port0 = 10'h0;
  logic [9:0]  in_port1 = 10'h0;
  logic [31:0] mmo;
  logic [31:0] out_port0, out_port1, out_port2;

  logic [31:0] exp_q [$];
  logic [31:0] mem_model [32];
  logic [31:0] exp_v;
  int          checks = 0;
  int          errors = 0;

  pipe_mem_io_stage dut (
    .clock     (clock),
    .resetn    (resetn),
    .mwmem     (mwmem),
    .malu      (malu),
    .mb        (mb),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .mmo       (mmo),
    .out_port0 (out_port0),
    .out_port1 (out_port1),
    .out_port2 (out_port2)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Drive one MEM-stage request at the falling edge (mid-cycle).
  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clock);
    mwmem = we;
    malu  = addr;
    mb    = data;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [6];
    addrs = '{32'hC0, 32'hC4, 32'hC8, 32'h80, 32'h84, 32'hD0};
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, addrs[i], 32'h0);
      exp_q.push_back(32'h0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (mmo !== exp_v) begin
        errors++;
        $display("FAIL reset_load addr=%h got=%h exp=%h", addrs[i], mmo, exp_v);
      end
    end
    checks++;
    if (out_port0 !== 32'h0) begin errors++; $display("FAIL reset_out0 got=%h exp=0", out_port0); end
    checks++;
    if (out_port1 !== 32'h0) begin errors++; $display("FAIL reset_out1 got=%h exp=0", out_port1); end
    checks++;
    if (out_port2 !== 32'h0) begin errors++; $display("FAIL reset_out2 got=%h exp=0", out_port2); end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_ram();
    logic [31:0] addrs [3];
    addrs = '{32'h0C, 32'h0D, 32'h10C};
    drive(1'b1, 32'h0C, 32'h11111111);
    mem_model[3] = 32'h11111111;
    // Second store: mmo must still show the pre-store word.
    drive(1'b1, 32'h0C, 32'hDEADBEEF);
    exp_q.push_back(mem_model[3]);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mmo !== exp_v) begin errors++; $display("FAIL ram_no_forward got=%h exp=%h", mmo, exp_v); end
    mem_model[3] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, addrs[i], 32'h0);
      exp_q.push_back(mem_model[3]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (mmo !== exp_v) begin
        errors++;
        $display("FAIL ram_load addr=%h got=%h exp=%h", addrs[i], mmo, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h20 + 32'(4 * i), 32'hC0DE0000 ^ (32'(i) * 32'h01010101));
      mem_model[8 + i] = 32'hC0DE0000 ^ (32'(i) * 32'h01010101);
    end
    for (int i = 7; i >= 0; i--) begin
      drive(1'b0, 32'h20 + 32'(4 * i), 32'h0);
      exp_q.push_back(mem_model[8 + i]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (mmo !== exp_v) begin
        errors++;
        $display("FAIL b2b_load idx=%0d got=%h exp=%h", 8 + i, mmo, exp_v);
      end
    end
    // Word 3 must be untouched by the burst.
    drive(1'b0, 32'h0C, 32'h0);
    exp_q.push_back(mem_model[3]);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mmo !== exp_v) begin errors++; $display("FAIL b2b_other_word got=%h exp=%h", mmo, exp_v); end
  endtask

  task automatic test_io_store();
    drive(1'b1, 32'hC4, 32'h12345678);
    drive(1'b0, 32'hC4, 32'h0);
    exp_q.push_back(32'h12345678);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mmo !== exp_v) begin errors++; $display("FAIL out1_readback got=%h exp=%h", mmo, exp_v); end
    checks++;
    if (out_port1 !== 32'h12345678) begin errors++; $display("FAIL out1_port got=%h exp=12345678", out_port1); end
    checks++;
    if (out_port0 !== 32'h0 || out_port2 !== 32'h0) begin
      errors++; $display("FAIL out1_isolation out0=%h out2=%h exp=0", out_port0, out_port2);
    end
    drive(1'b1, 32'hC0, 32'hAAAA5555);
    drive(1'b1, 32'h1C8, 32'h0F0F0F0F);   // aliased address of out2
    drive(1'b0, 32'hC0, 32'h0);
    exp_q.push_back(32'hAAAA5555);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mmo !== exp_v) begin errors++; $display("FAIL out0_readback got=%h exp=%h", mmo, exp_v); end
    checks++;
    if (out_port2 !== 32'h0F0F0F0F) begin errors++; $display("FAIL out2_alias got=%h exp=0f0f0f0f", out_port2); end
    // Stores to a read-only and an unmapped address are dropped.
    drive(1'b1, 32'h80, 32'hFFFFFFFF);
    drive(1'b1, 32'h94, 32'hFFFFFFFF);
    drive(1'b0, 32'h80, 32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mmo !== exp_v) begin errors++; $display("FAIL ro_store_drop got=%h exp=%h", mmo, exp_v); end
    drive(1'b0, 32'h94, 32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mmo !== exp_v) begin errors++; $display("FAIL unmapped_read got=%h exp=%h", mmo, exp_v); end
    checks++;
    if (out_port0 !== 32'hAAAA5555 || out_port1 !== 32'h12345678 || out_port2 !== 32'h0F0F0F0F) begin
      errors++;
      $display("FAIL ports_after_drop out0=%h out1=%h out2=%h exp=aaaa5555/12345678/0f0f0f0f",
               out_port0, out_port1, out_port2);
    end
  endtask

  task automatic test_input_sync();
    logic [31:0] exp_seq [3];
    exp_seq = '{32'h0, 32'h0, 32'h2A5};
    drive(1'b0, 32'h80, 32'h0);
    in_port0 = 10'h2A5;
    in_port1 = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      exp_q.push_back(exp_seq[i]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (mmo !== exp_v) begin
        errors++;
        $display("FAIL sync_in0 edges=%0d got=%h exp=%h", i, mmo, exp_v);
      end
    end
    drive(1'b0, 32'h84, 32'h0);
    exp_q.push_back(32'h000003FF);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mmo !== exp_v) begin errors++; $display("FAIL sync_in1 got=%h exp=%h", mmo, exp_v); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h04, 32'h00000055);
    mem_model[1] = 32'h00000055;
    // Store presented on the reset edge must be dropped.
    @(negedge clock);
    resetn = 1'b0;
    mwmem  = 1'b1;
    malu   = 32'h04;
    mb     = 32'h00000099;
    @(negedge clock);
    resetn = 1'b1;
    mwmem  = 1'b0;
    malu   = 32'hD0;
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mmo !== exp_v) begin errors++; $display("FAIL rst_timer_clear got=%h exp=%h", mmo, exp_v); end
    checks++;
    if (out_port0 !== 32'h0 || out_port1 !== 32'h0 || out_port2 !== 32'h0) begin
      errors++;
      $display("FAIL rst_ports out0=%h out1=%h out2=%h exp=0", out_port0, out_port1, out_port2);
    end
    drive(1'b0, 32'h80, 32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mmo !== exp_v) begin errors++; $display("FAIL rst_sync_clear got=%h exp=%h", mmo, exp_v); end
    drive(1'b0, 32'h80, 32'h0);
    exp_q.push_back(32'h2A5);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mmo !== exp_v) begin errors++; $display("FAIL rst_sync_refill got=%h exp=%h", mmo, exp_v); end
    drive(1'b0, 32'h04, 32'h0);
    exp_q.push_back(mem_model[1]);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (mmo !== exp_v) begin errors++; $display("FAIL rst_ram_retained got=%h exp=%h", mmo, exp_v); end
  endtask

  task automatic test_timer();
    logic [31:0] exp_seq [4];
`ifdef PIPE_MEM_TIMER_EN
    exp_seq = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
`else
    exp_seq = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
    drive(1'b1, 32'hD0, 32'hFFFFFFFE);
    drive(1'b0, 32'hD0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      exp_q.push_back(exp_seq[i]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (mmo !== exp_v) begin
        errors++;
        $display("FAIL timer step=%0d got=%h exp=%h", i, mmo, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_back_to_back();
    test_io_store();
    test_input_sync();
    test_reset_mid();
    test_timer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
